// File: rtl/uart_rx_frame_pkg.sv
// Shared UART definitions: state encoding, default oversample rate, helpers.
package uart_rx_frame_pkg;

  localparam int NUM_TICKS_DEF = 16;

  // One-hot states; any other encoding is treated as illegal and recovers to IDLE.
  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Even parity: running XOR of the data bits.
  function automatic logic par_next(input logic acc, input logic b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Line-side inputs, frame config and host-side results of the UART receiver.
interface uart_rx_frame_if #(
  parameter int BITS_PER_DATA = 8
);
  logic                     tick;
  logic                     rx_in;
  logic                     parity;
  logic [1:0]               stop_bits;
  logic [BITS_PER_DATA-1:0] d_out;
  logic                     rx_done;
  logic                     parity_err;
  logic                     frame_err;

  modport master (
    output tick, rx_in, parity, stop_bits,
    input  d_out, rx_done, parity_err, frame_err
  );

  modport slave (
    input  tick, rx_in, parity, stop_bits,
    output d_out, rx_done, parity_err, frame_err
  );
endinterface

// File: rtl/uart_rx_frame_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; resets to idle (1).
module uart_rx_frame_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);
  logic [SYNC_STAGES-1:0] r_sync;

  // Shift the raw line through the chain; reset to 1 so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) r_sync <= '1;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: 16x oversampled line -> one word per frame with parity/framing status.
module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int NUM_TICKS     = NUM_TICKS_DEF,
  parameter int BITS_PER_DATA = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic            clk,
  input  logic            reset,
  uart_rx_frame_if.slave  bus
);
  localparam int S_W = clog2(NUM_TICKS);
  localparam int N_W = clog2(BITS_PER_DATA);
  localparam logic [S_W-1:0] S_MID  = S_W'(NUM_TICKS/2 - 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(NUM_TICKS - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(BITS_PER_DATA - 1);

  logic w_rx_s;

  uart_rx_frame_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.rx_in),
    .o_q   (w_rx_s)
  );

  state_e                   r_state, w_state_nxt;
  logic [S_W-1:0]           r_s, w_s_nxt;
  logic [N_W-1:0]           r_n, w_n_nxt;
  logic [BITS_PER_DATA-1:0] r_sr, w_sr_nxt;
  logic                     r_acc, w_acc_nxt;
  logic                     r_perr, w_perr_nxt;
  logic                     r_ferr, w_ferr_nxt;
  logic [1:0]               r_stop_cnt, w_stop_cnt_nxt;
  logic [1:0]               r_stop_num, w_stop_num_nxt;
  logic                     r_par_en, w_par_en_nxt;
  logic                     w_done;
  logic [BITS_PER_DATA-1:0] r_d_out;
  logic                     r_rx_done, r_parity_err, r_frame_err;

  // Next-state / datapath: every sample point is a tick at a specific s value.
  always_comb begin
    w_state_nxt    = r_state;
    w_s_nxt        = r_s;
    w_n_nxt        = r_n;
    w_sr_nxt       = r_sr;
    w_acc_nxt      = r_acc;
    w_perr_nxt     = r_perr;
    w_ferr_nxt     = r_ferr;
    w_stop_cnt_nxt = r_stop_cnt;
    w_stop_num_nxt = r_stop_num;
    w_par_en_nxt   = r_par_en;
    w_done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_s_nxt = '0;
        if (!w_rx_s) begin
          // Frame config is latched here and held until the frame ends.
          w_state_nxt    = ST_START;
          w_n_nxt        = '0;
          w_acc_nxt      = 1'b0;
          w_perr_nxt     = 1'b0;
          w_ferr_nxt     = 1'b0;
          w_stop_cnt_nxt = 2'd0;
          w_par_en_nxt   = bus.parity;
          w_stop_num_nxt = (bus.stop_bits == 2'd0) ? 2'd1 : bus.stop_bits;
        end
      end
      ST_START: if (bus.tick) begin
        if (r_s == S_MID) begin
          w_s_nxt     = '0;
          w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;  // high at mid-start = glitch
        end else begin
          w_s_nxt = r_s + S_W'(1);
        end
      end
      ST_DATA: if (bus.tick) begin
        if (r_s == S_LAST) begin
          w_s_nxt   = '0;
          w_sr_nxt  = {w_rx_s, r_sr[BITS_PER_DATA-1:1]};
          w_acc_nxt = par_next(r_acc, w_rx_s);
          if (r_n == N_LAST) begin
            w_n_nxt     = '0;
            w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
          end else begin
            w_n_nxt = r_n + N_W'(1);
          end
        end else begin
          w_s_nxt = r_s + S_W'(1);
        end
      end
      ST_PARITY: if (bus.tick) begin
        if (r_s == S_LAST) begin
          w_s_nxt     = '0;
          w_perr_nxt  = r_acc ^ w_rx_s;
          w_state_nxt = ST_STOP;
        end else begin
          w_s_nxt = r_s + S_W'(1);
        end
      end
      ST_STOP: if (bus.tick) begin
        if (r_s == S_LAST) begin
          w_s_nxt    = '0;
          w_ferr_nxt = r_ferr | ~w_rx_s;
          // Finish at mid-stop so a back-to-back start edge is still seen from IDLE.
          if (r_stop_cnt == r_stop_num - 2'd1) begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_stop_cnt_nxt = r_stop_cnt + 2'd1;
          end
        end else begin
          w_s_nxt = r_s + S_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, counters and result registers; reset discards any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_s          <= '0;
      r_n          <= '0;
      r_sr         <= '0;
      r_acc        <= 1'b0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
      r_stop_cnt   <= 2'd0;
      r_stop_num   <= 2'd1;
      r_par_en     <= 1'b0;
      r_d_out      <= '0;
      r_rx_done    <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_s        <= w_s_nxt;
      r_n        <= w_n_nxt;
      r_sr       <= w_sr_nxt;
      r_acc      <= w_acc_nxt;
      r_perr     <= w_perr_nxt;
      r_ferr     <= w_ferr_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_stop_num <= w_stop_num_nxt;
      r_par_en   <= w_par_en_nxt;
      r_rx_done  <= w_done;
      if (w_done) begin
        r_d_out      <= r_sr;
        r_parity_err <= w_perr_nxt;
        r_frame_err  <= w_ferr_nxt;
      end
    end
  end

  assign bus.d_out      = r_d_out;
  assign bus.rx_done    = r_rx_done;
  assign bus.parity_err = r_parity_err;
  assign bus.frame_err  = r_frame_err;
endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: directed frames, expectations queued at send time.
module tb_uart_rx_frame;
  localparam int BIT_CLKS = 64;  // 16 ticks per bit, tick every 4 clk

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  uart_rx_frame_if #(.BITS_PER_DATA(8)) bus ();

  uart_rx_frame dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Oversample strobe: one clk high out of every four.
  initial begin
    int c;
    c = 0;
    bus.tick = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.tick = (c == 3);
      c = (c + 1) % 4;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every rx_done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && bus.rx_done === 1'b1) begin
      if (q.size() == 0) begin
        chk("rx_done_unexpected", {31'd0, bus.rx_done}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("d_out", {24'd0, bus.d_out}, {24'd0, e.d});
        chk("parity_err", {31'd0, bus.parity_err}, {31'd0, e.pe});
        chk("frame_err", {31'd0, bus.frame_err}, {31'd0, e.fe});
      end
    end
  end

  task automatic send_bit(input logic b);
    bus.rx_in = b;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  // Bad stop bit: low through the mid-sample, then back high early enough that the
  // receiver's restart from IDLE sees a glitch rather than a new start bit.
  task automatic send_bad_stop();
    bus.rx_in = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    bus.rx_in = 1'b1;
    repeat (BIT_CLKS + 24) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input int nstop, input logic stop_ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pen) send_bit(pbit);
    for (int k = 0; k < nstop; k++) begin
      if (stop_ok) send_bit(1'b1);
      else         send_bad_stop();
    end
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe;
    q.push_back(e);
  endtask

  task automatic wait_drain(input string nm);
    int k;
    k = 0;
    while (q.size() != 0 && k < 400) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk(nm, q.size(), 32'd0);
  endtask

  task automatic idle(input int n);
    bus.rx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_d_out"}, {24'd0, bus.d_out}, 32'd0);
    chk({tag, "_rx_done"}, {31'd0, bus.rx_done}, 32'd0);
    chk({tag, "_parity_err"}, {31'd0, bus.parity_err}, 32'd0);
    chk({tag, "_frame_err"}, {31'd0, bus.frame_err}, 32'd0);
  endtask

  initial begin
    bus.rx_in     = 1'b1;
    bus.parity    = 1'b0;
    bus.stop_bits = 2'd1;
    reset         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    reset = 1'b0;
    idle(20);

    // 0xA5, no parity, 1 stop
    expect_frame(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0, 1, 1'b1);
    wait_drain("drain_a5");
    idle(30);

    // 0x07 with parity, 2 stops: XOR of data = 1
    bus.parity = 1'b1; bus.stop_bits = 2'd2;
    expect_frame(8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1, 2, 1'b1);
    wait_drain("drain_07_good");
    idle(30);
    expect_frame(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0, 2, 1'b1);
    wait_drain("drain_07_bad");
    idle(30);

    // Start glitch: low for 5 ticks only
    bus.parity = 1'b0; bus.stop_bits = 2'd1;
    bus.rx_in = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    idle(2 * BIT_CLKS);
    chk("glitch_d_out_held", {24'd0, bus.d_out}, 32'h07);

    // 0x3C with stop bit low -> frame error
    expect_frame(8'h3C, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b0, 1, 1'b0);
    wait_drain("drain_3c");
    idle(30);

    // Back-to-back 0x55 / 0xAA, 1 stop, no gap
    expect_frame(8'h55, 1'b0, 1'b0);
    expect_frame(8'hAA, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, 1, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b0, 1, 1'b1);
    wait_drain("drain_b2b");
    idle(30);

    // Reset for one clk in the middle of data bit 3 of 0x3C (bits 0..3 = 0,0,1,1)
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    bus.rx_in = 1'b1;
    repeat (BIT_CLKS/2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_outputs_zero("midreset");
    idle(4 * BIT_CLKS);
    chk_outputs_zero("post_midreset");

    // Clean frame after reset
    expect_frame(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0, 1, 1'b1);
    wait_drain("drain_81");
    idle(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #3_000_000;
    $display("FAIL timeout actual=running required=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "time limit");
  end
endmodule
